// File: rtl/updown_pkg.sv
// updown_pkg: shared direction/boundary-mode encodings for the up/down counter.
package updown_pkg;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/updown_prescaler.sv
// updown_prescaler: enable-gated phase counter; tick fires on the last phase of each PRESCALE window.
module updown_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
   logic [PW-1:0] phase_q, phase_d;
   assign tick = en && (phase_q == LAST);
   always_comb begin
      phase_d = clr ? '0 : !en ? phase_q : (phase_q == LAST) ? '0 : phase_q + 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   end
endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: prescaled up/down counter over [0, max_val] with wrap/saturate,
// terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_n
   import updown_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             updown,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   input  logic             sat,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);
   logic             tick, above, at_max, at_zero, ovf_set, unf_set;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d, ovf_q, ovf_d, unf_q, unf_d;
   updown_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .tick (tick)
   );
   // Boundaries are compared before stepping so the +1/-1 can never overflow.
   always_comb begin
      above   = count_q > max_val;
      at_max  = count_q == max_val;
      at_zero = count_q == '0;
      ovf_set = !load && tick && !above && updown == DIR_UP && at_max;
      unf_set = !load && tick && !above && updown == DIR_DOWN && at_zero;
      tc_d    = ovf_set || unf_set;
      ovf_d   = ovf_set || (ovf_q && !clr_flags);
      unf_d   = unf_set || (unf_q && !clr_flags);
      count_d = load     ? (load_val > max_val ? max_val : load_val)
              : !tick    ? count_q
              : above    ? max_val
              : ovf_set  ? (sat == MODE_SAT ? count_q : '0)
              : unf_set  ? (sat == MODE_SAT ? count_q : max_val)
              : updown == DIR_UP ? count_q + 1'b1 : count_q - 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end
   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;
endmodule

// File: tb/tb_updown_counter_n.sv
// tb_updown_counter_n: directed scenarios plus randomized traffic on PRESCALE=1 and PRESCALE=4 instances,
// checked against an arithmetic reference model.
module tb_updown_counter_n;
   logic       clk = 1'b0;
   logic       rst = 1'b0, en = 1'b0, updown = 1'b0, load = 1'b0, sat = 1'b0, clr_flags = 1'b0;
   logic [7:0] load_val = '0, max_val = '0;
   logic [7:0] count_o [2];
   logic       tc_o [2], ovf_o [2], unf_o [2];
   int         m_cnt [2], m_ph [2];
   bit         m_tc [2], m_ovf [2], m_unf [2];
   int         n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   updown_counter_n #(.WIDTH(8), .PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
      .max_val(max_val), .sat(sat), .clr_flags(clr_flags),
      .count(count_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0])
   );
   updown_counter_n #(.WIDTH(8), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
      .max_val(max_val), .sat(sat), .clr_flags(clr_flags),
      .count(count_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1])
   );

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end
   endtask

   task automatic model_edge();
      int pre, mx;
      bit tk, so, su;
      mx = int'(max_val);
      for (int i = 0; i < 2; i++) begin
         pre = (i == 0) ? 1 : 4;
         tk  = en && (m_ph[i] == pre - 1);
         so  = 0;
         su  = 0;
         if (load) begin
            m_cnt[i] = (int'(load_val) > mx) ? mx : int'(load_val);
            m_ph[i]  = 0;
         end else begin
            if (en) m_ph[i] = (m_ph[i] + 1) % pre;
            if (tk) begin
               if (m_cnt[i] > mx) m_cnt[i] = mx;
               else if (updown) begin
                  if (m_cnt[i] == mx) begin so = 1; if (!sat) m_cnt[i] = 0; end
                  else m_cnt[i] = m_cnt[i] + 1;
               end else begin
                  if (m_cnt[i] == 0) begin su = 1; if (!sat) m_cnt[i] = mx; end
                  else m_cnt[i] = m_cnt[i] - 1;
               end
            end
         end
         m_tc[i]  = so || su;
         m_ovf[i] = so || (m_ovf[i] && !clr_flags);
         m_unf[i] = su || (m_unf[i] && !clr_flags);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_async dut%0d: got %h want 000", i, {count_o[i], tc_o[i], ovf_o[i], unf_o[i]});
         end
      end
      en = 1'b1; updown = 1'b1; max_val = 8'd9;
      step();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_held dut%0d: got %h want 000", i, {count_o[i], tc_o[i], ovf_o[i], unf_o[i]});
         end
      end
      rst = 1'b0;
      en = 1'b0;
      model_clear();
   endtask

   task automatic test_wrap_up();
      do_reset();
      max_val = 8'd9; sat = 1'b0; updown = 1'b1; en = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         step();
         n_cmp++;
         if (count_o[0] !== 8'(k % 10) || tc_o[0] !== (k == 10) || ovf_o[0] !== (k >= 10)) begin
            n_bad++;
            $display("FAIL wrap_up edge%0d: got cnt=%0d tc=%b ovf=%b want cnt=%0d tc=%b ovf=%b",
                     k, count_o[0], tc_o[0], ovf_o[0], k % 10, k == 10, k >= 10);
         end
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]}) begin
               n_bad++;
               $display("FAIL wrap_up_model dut%0d: got %h want %h", i,
                        {count_o[i], tc_o[i], ovf_o[i], unf_o[i]}, {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]});
            end
         end
      end
      en = 1'b0;
      step();
      step();
      n_cmp++;
      if (ovf_o[0] !== 1'b1 || tc_o[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_sticky: got ovf=%b tc=%b want ovf=1 tc=0", ovf_o[0], tc_o[0]);
      end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      n_cmp++;
      if (ovf_o[0] !== 1'b0 || ovf_o[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear: got ovf=%b/%b want 0/0", ovf_o[0], ovf_o[1]);
      end
   endtask

   task automatic test_sat_down();
      logic [7:0] exp_c [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
      logic       exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      max_val = 8'd9; load_val = 8'd2; load = 1'b1; en = 1'b1;
      step();
      load = 1'b0; sat = 1'b1; updown = 1'b0;
      n_cmp++;
      if (count_o[0] !== 8'd2) begin
         n_bad++;
         $display("FAIL sat_down_load: got cnt=%0d want 2", count_o[0]);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         n_cmp++;
         if (count_o[0] !== exp_c[k] || tc_o[0] !== exp_t[k] || unf_o[0] !== exp_t[k]) begin
            n_bad++;
            $display("FAIL sat_down tick%0d: got cnt=%0d tc=%b unf=%b want cnt=%0d tc=%b unf=%b",
                     k, count_o[0], tc_o[0], unf_o[0], exp_c[k], exp_t[k], exp_t[k]);
         end
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]}) begin
               n_bad++;
               $display("FAIL sat_down_model dut%0d: got %h want %h", i,
                        {count_o[i], tc_o[i], ovf_o[i], unf_o[i]}, {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]});
            end
         end
      end
   endtask

   task automatic test_load_clamp();
      max_val = 8'd100; load_val = 8'd200; load = 1'b1; en = 1'b1; updown = 1'b1;
      step();
      load = 1'b0; en = 1'b0;
      n_cmp++;
      if (count_o[0] !== 8'd100 || tc_o[0] !== 1'b0 || unf_o[0] !== 1'b1 || ovf_o[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL load_clamp: got cnt=%0d tc=%b ovf=%b unf=%b want cnt=100 tc=0 ovf=0 unf=1",
                  count_o[0], tc_o[0], ovf_o[0], unf_o[0]);
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]}) begin
            n_bad++;
            $display("FAIL load_clamp_model dut%0d: got %h want %h", i,
                     {count_o[i], tc_o[i], ovf_o[i], unf_o[i]}, {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]});
         end
      end
   endtask

   task automatic test_prescaler();
      int exp_c [14] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3};
      max_val = 8'd100; load_val = 8'd0; load = 1'b1; en = 1'b1; sat = 1'b0;
      step();
      load = 1'b0; updown = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         en = !(k == 10 || k == 11);
         step();
         n_cmp++;
         if (count_o[1] !== 8'(exp_c[k-1])) begin
            n_bad++;
            $display("FAIL prescale edge%0d: got cnt=%0d want %0d", k, count_o[1], exp_c[k-1]);
         end
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]}) begin
               n_bad++;
               $display("FAIL prescale_model dut%0d: got %h want %h", i,
                        {count_o[i], tc_o[i], ovf_o[i], unf_o[i]}, {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]});
            end
         end
      end
   endtask

   task automatic test_async_reset();
      max_val = 8'd100; load_val = 8'd5; load = 1'b1;
      step();
      load = 1'b0; en = 1'b1; updown = 1'b1;
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== 11'h0) begin
            n_bad++;
            $display("FAIL async_reset dut%0d: got %h want 000", i, {count_o[i], tc_o[i], ovf_o[i], unf_o[i]});
         end
      end
      #1 rst = 1'b0;
      model_clear();
      step();
      n_cmp++;
      if (count_o[0] !== 8'd1 || count_o[1] !== 8'd0) begin
         n_bad++;
         $display("FAIL async_restart: got cnt=%0d/%0d want 1/0", count_o[0], count_o[1]);
      end
   endtask

   task automatic test_flag_collision();
      max_val = 8'd9; load_val = 8'd9; load = 1'b1; en = 1'b1;
      step();
      load = 1'b0; updown = 1'b1; sat = 1'b0; clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      n_cmp++;
      if (ovf_o[0] !== 1'b1 || tc_o[0] !== 1'b1 || count_o[0] !== 8'd0) begin
         n_bad++;
         $display("FAIL flag_collision: got ovf=%b tc=%b cnt=%0d want ovf=1 tc=1 cnt=0", ovf_o[0], tc_o[0], count_o[0]);
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]}) begin
            n_bad++;
            $display("FAIL flag_collision_model dut%0d: got %h want %h", i,
                     {count_o[i], tc_o[i], ovf_o[i], unf_o[i]}, {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]});
         end
      end
   endtask

   task automatic test_max_lower();
      logic [7:0] mv [4] = '{8'd20, 8'd0, 8'd0, 8'd0};
      logic       ud [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] ec [4] = '{8'd20, 8'd0, 8'd0, 8'd0};
      logic       et [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      max_val = 8'd100; load_val = 8'd50; load = 1'b1; sat = 1'b0;
      step();
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         max_val = mv[k];
         updown = ud[k];
         step();
         n_cmp++;
         if (count_o[0] !== ec[k] || tc_o[0] !== et[k]) begin
            n_bad++;
            $display("FAIL max_lower step%0d: got cnt=%0d tc=%b want cnt=%0d tc=%b", k, count_o[0], tc_o[0], ec[k], et[k]);
         end
      end
      n_cmp++;
      if (ovf_o[0] !== 1'b1 || unf_o[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL max_zero_flags: got ovf=%b unf=%b want 1 1", ovf_o[0], unf_o[0]);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         en        = ($urandom % 4) != 0;
         updown    = $urandom % 2;
         sat       = $urandom % 2;
         load      = ($urandom % 16) == 0;
         load_val  = 8'($urandom);
         clr_flags = ($urandom % 10) == 0;
         if ($urandom % 20 == 0) begin
            case ($urandom % 4)
               0: max_val = 8'd0;
               1: max_val = 8'($urandom % 16);
               2: max_val = 8'd255;
               default: max_val = 8'($urandom);
            endcase
         end
         step();
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({count_o[i], tc_o[i], ovf_o[i], unf_o[i]} !== {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]}) begin
               n_bad++;
               $display("FAIL random_model cyc%0d dut%0d: got %h want %h", k, i,
                        {count_o[i], tc_o[i], ovf_o[i], unf_o[i]}, {8'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i]});
            end
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_wrap_up();
      test_sat_down();
      test_load_clamp();
      test_prescaler();
      test_async_reset();
      test_flag_collision();
      test_max_lower();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
